// File: rtl/adc_lane_align.sv
// ---------------------------------------------------------------------------
// adc_lane_align
//   Calibrates one ADC data lane: sweeps the input delay across all 512 taps,
//   finds the widest contiguous run of taps where the training nibble is
//   received stably, centers the delay in that run, then searches the four
//   bit offsets (slip) for the one that reproduces TRAIN_PATTERN on dout.
//
// Ports
//   clk              in   single clock, rising edge
//   rst_n            in   asynchronous assert, synchronous release, active-low
//   start            in   one-cycle pulse, begins calibration (ignored if busy)
//   din[3:0]         in   deserialized nibble from the input SERDES
//   delay_count_out  out  tap value for the input delay CNTVALUEIN
//   delay_load       out  one-cycle load strobe for the input delay
//   dout[3:0]        out  bit-aligned data, bits [slip+3:slip] of {din, din_d1}
//   slip[1:0]        out  selected bit offset
//   eye_width[8:0]   out  length of the best good-tap run (saturates at 511)
//   busy/done/fail   out  status flags
// ---------------------------------------------------------------------------
module adc_lane_align #(
    parameter logic [3:0]  TRAIN_PATTERN = 4'b0011,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned CHECK_CYCLES  = 64,
    parameter int unsigned MIN_EYE       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] din,
    output logic [8:0] delay_count_out,
    output logic       delay_load,
    output logic [3:0] dout,
    output logic [1:0] slip,
    output logic [8:0] eye_width,
    output logic       busy,
    output logic       done,
    output logic       fail
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_CHECK,
        S_NEXT,
        S_CENTER_LOAD,
        S_CENTER_SETTLE,
        S_SLIP_CHECK,
        S_DONE,
        S_FAIL
    } state_t;

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] CHECK_LAST  = 16'(CHECK_CYCLES - 1);
    // Slip trials skip two cycles so dout reflects the new offset
    localparam logic [15:0] SLIP_LAST   = 16'(CHECK_CYCLES + 1);
    localparam logic [9:0]  MIN_EYE_W   = 10'(MIN_EYE);

    state_t      state_q;
    logic [8:0]  tap_q;
    logic        load_q;
    logic [3:0]  din_d1_q;
    logic [3:0]  dout_q;
    logic [1:0]  slip_q;
    logic [8:0]  eye_q;
    logic        busy_q;
    logic        done_q;
    logic        fail_q;
    logic [15:0] cnt_q;
    logic [3:0]  first_q;
    logic        ok_q;
    logic        match_q;
    logic [9:0]  cur_len_q;
    logic [8:0]  cur_start_q;
    logic [9:0]  best_len_q;
    logic [8:0]  best_start_q;

    logic        rot_ok;
    logic        ok_d;
    logic        match_d;
    logic [3:0]  dout_d;
    logic [9:0]  cur_len_d;
    logic [8:0]  cur_start_d;
    logic [9:0]  best_len_d;
    logic [8:0]  best_start_d;
    logic [8:0]  center_d;
    logic [8:0]  eye_d;

    always_comb begin
        rot_ok = (din == TRAIN_PATTERN)
              || (din == {TRAIN_PATTERN[2:0], TRAIN_PATTERN[3]})
              || (din == {TRAIN_PATTERN[1:0], TRAIN_PATTERN[3:2]})
              || (din == {TRAIN_PATTERN[0],   TRAIN_PATTERN[3:1]});

        // First sample of the window sets the reference; later samples must repeat it
        ok_d = (cnt_q == '0) ? rot_ok : (ok_q && (din == first_q));

        match_d = (cnt_q < 16'd2) ? match_q : (match_q && (dout_q == TRAIN_PATTERN));

        case (slip_q)
            2'd0:    dout_d = din_d1_q;
            2'd1:    dout_d = {din[0],   din_d1_q[3:1]};
            2'd2:    dout_d = {din[1:0], din_d1_q[3:2]};
            default: dout_d = {din[2:0], din_d1_q[3]};
        endcase

        cur_len_d   = ok_q ? (cur_len_q + 10'd1) : '0;
        cur_start_d = (ok_q && (cur_len_q == '0)) ? tap_q : cur_start_q;

        // Best is refreshed while a run grows; a strictly-longer test here
        // gives the same result as comparing at run close, including a run
        // still open at tap 511, and keeps the lowest-start run on ties.
        if (cur_len_d > best_len_q) begin
            best_len_d   = cur_len_d;
            best_start_d = cur_start_d;
        end else begin
            best_len_d   = best_len_q;
            best_start_d = best_start_q;
        end

        center_d = 9'({1'b0, best_start_d} + (best_len_d >> 1));
        eye_d    = (best_len_d > 10'd511) ? 9'd511 : best_len_d[8:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            tap_q        <= '0;
            load_q       <= 1'b0;
            din_d1_q     <= '0;
            dout_q       <= '0;
            slip_q       <= '0;
            eye_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            cnt_q        <= '0;
            first_q      <= '0;
            ok_q         <= 1'b0;
            match_q      <= 1'b0;
            cur_len_q    <= '0;
            cur_start_q  <= '0;
            best_len_q   <= '0;
            best_start_q <= '0;
        end else begin
            din_d1_q <= din;
            dout_q   <= dout_d;
            load_q   <= 1'b0;

            case (state_q)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (start) begin
                        state_q      <= S_LOAD;
                        tap_q        <= '0;
                        slip_q       <= '0;
                        cur_len_q    <= '0;
                        cur_start_q  <= '0;
                        best_len_q   <= '0;
                        best_start_q <= '0;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        fail_q       <= 1'b0;
                    end
                end

                // tap_q was set on entry, so the value is stable a cycle before the strobe
                S_LOAD: begin
                    load_q  <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= S_SETTLE;
                end

                S_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_CHECK;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                S_CHECK: begin
                    ok_q <= ok_d;
                    if (cnt_q == '0) begin
                        first_q <= din;
                    end
                    if (cnt_q == CHECK_LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_NEXT;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                S_NEXT: begin
                    cur_len_q    <= cur_len_d;
                    cur_start_q  <= cur_start_d;
                    best_len_q   <= best_len_d;
                    best_start_q <= best_start_d;
                    if (tap_q != 9'd511) begin
                        tap_q   <= tap_q + 9'd1;
                        state_q <= S_LOAD;
                    end else begin
                        eye_q <= eye_d;
                        if (best_len_d < MIN_EYE_W) begin
                            state_q <= S_FAIL;
                            busy_q  <= 1'b0;
                            fail_q  <= 1'b1;
                        end else begin
                            tap_q   <= center_d;
                            state_q <= S_CENTER_LOAD;
                        end
                    end
                end

                S_CENTER_LOAD: begin
                    load_q  <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= S_CENTER_SETTLE;
                end

                S_CENTER_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_q   <= '0;
                        match_q <= 1'b1;
                        state_q <= S_SLIP_CHECK;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                S_SLIP_CHECK: begin
                    match_q <= match_d;
                    if (cnt_q == SLIP_LAST) begin
                        cnt_q <= '0;
                        if (match_d) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else if (slip_q != 2'd3) begin
                            slip_q  <= slip_q + 2'd1;
                            match_q <= 1'b1;
                        end else begin
                            state_q <= S_FAIL;
                            busy_q  <= 1'b0;
                            fail_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign delay_count_out = tap_q;
    assign delay_load      = load_q;
    assign dout            = dout_q;
    assign slip            = slip_q;
    assign eye_width       = eye_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign fail            = fail_q;

endmodule
